// File: rtl/cndm_msi_pkg.sv
// cndm_msi_pkg
// Shared types and constants for the cndm MSI interrupt controller.
//   msi_state_t  : controller FSM state (IDLE, ISSUE, WAIT, BACKOFF)
//   MSI_VEC_MAX  : width of the MSI vector space on the PCIe core port
package cndm_msi_pkg;

  localparam int MSI_VEC_MAX = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    BACKOFF = 2'd3
  } msi_state_t;

endpackage

// File: rtl/cndm_msi_rr_sel.sv
// cndm_msi_rr_sel
// Combinational round-robin find-first over the 32-bit MSI vector space.
// Returns the lowest set request index at or above the pointer, wrapping
// past bit 31 back to bit 0.
//   i_req   : request bits
//   i_ptr   : search start index
//   o_valid : at least one request bit set
//   o_index : selected index (0 when o_valid is low)
module cndm_msi_rr_sel
  import cndm_msi_pkg::*;
(
  input  logic [MSI_VEC_MAX-1:0] i_req,
  input  logic [4:0]             i_ptr,
  output logic                   o_valid,
  output logic [4:0]             o_index
);

  logic [4:0] w_idx;

  // Scan offsets from the far end down so the smallest offset from the
  // pointer is the last one to write the result and therefore wins.
  always_comb begin
    o_valid = 1'b0;
    o_index = 5'd0;
    w_idx   = 5'd0;
    for (int k = MSI_VEC_MAX - 1; k >= 0; k--) begin
      w_idx = i_ptr + 5'(k);
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/cndm_msi_irq_ctrl.sv
// cndm_msi_irq_ctrl
// Collects per-vector interrupt pulses from the cndm datapath, coalesces
// them into a pending register and issues them one at a time on the PCIe
// core cfg_interrupt_msi_* port (function 0), retrying after a backoff on
// failure.
//   clk, rst                        : pcie_clk, async active-high reset
//   irq_req                         : per-vector request pulses
//   irq_busy                        : FSM not idle
//   cfg_interrupt_msi_enable/mmenable : MSI enable / log2 vector count
//   cfg_interrupt_msi_mask_update/data: per-vector mask load
//   cfg_interrupt_msi_int           : one-hot MSI request (one cycle)
//   cfg_interrupt_msi_sent/fail     : core response pulses
//   cfg_interrupt_msi_pending_status(+_data_enable): pending mirror
//   remaining cfg_interrupt_msi_* outputs: tied to 0 (function 0, no TPH)
//   dbg_state                       : current FSM state
//
// Core handshake: the controller raises exactly one bit of
// cfg_interrupt_msi_int for a single cycle, then waits indefinitely for a
// one-cycle sent or fail pulse from the core. Only one request is ever in
// flight; responses outside of the wait state are ignored. fail wins when
// both arrive together.
module cndm_msi_irq_ctrl
  import cndm_msi_pkg::*;
#(
  parameter int IRQ_CNT     = 32,
  parameter int RETRY_DELAY = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_CNT-1:0] irq_req,
  output logic               irq_busy,
  input  logic [3:0]         cfg_interrupt_msi_enable,
  input  logic [11:0]        cfg_interrupt_msi_mmenable,
  input  logic               cfg_interrupt_msi_mask_update,
  input  logic [31:0]        cfg_interrupt_msi_data,
  output logic [1:0]         cfg_interrupt_msi_select,
  output logic [31:0]        cfg_interrupt_msi_int,
  output logic [31:0]        cfg_interrupt_msi_pending_status,
  output logic               cfg_interrupt_msi_pending_status_data_enable,
  output logic [1:0]         cfg_interrupt_msi_pending_status_function_num,
  input  logic               cfg_interrupt_msi_sent,
  input  logic               cfg_interrupt_msi_fail,
  output logic [2:0]         cfg_interrupt_msi_attr,
  output logic               cfg_interrupt_msi_tph_present,
  output logic [1:0]         cfg_interrupt_msi_tph_type,
  output logic [7:0]         cfg_interrupt_msi_tph_st_tag,
  output logic [7:0]         cfg_interrupt_msi_function_number,
  output logic [1:0]         dbg_state
);

  localparam int CNT_W = $clog2(RETRY_DELAY + 1);

  msi_state_t             r_state;
  logic [MSI_VEC_MAX-1:0] r_pending;
  logic [MSI_VEC_MAX-1:0] r_mask;
  logic [MSI_VEC_MAX-1:0] r_int;
  logic                   r_pde;
  logic [4:0]             r_rr;
  logic [4:0]             r_sel;
  logic [CNT_W-1:0]       r_cnt;

  logic [2:0]             w_mm;
  logic [4:0]             w_vmask;
  logic [MSI_VEC_MAX-1:0] w_req_fold;
  logic [MSI_VEC_MAX-1:0] w_elig;
  logic [MSI_VEC_MAX-1:0] w_pend_next;
  logic                   w_sel_valid;
  logic [4:0]             w_sel_idx;
  logic                   w_unused;

  assign w_unused = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

  // Allocated vector count is 2^mm, capped at 32 vectors.
  assign w_mm    = cfg_interrupt_msi_mmenable[2:0];
  assign w_vmask = (w_mm >= 3'd5) ? 5'h1f : 5'((6'd1 << w_mm) - 6'd1);

  // Requests beyond the allocated range alias onto lower vectors.
  always_comb begin
    w_req_fold = '0;
    for (int i = 0; i < IRQ_CNT; i++) begin
      if (irq_req[i]) w_req_fold[5'(i) & w_vmask] = 1'b1;
    end
  end

  assign w_elig = r_pending & ~r_mask & {MSI_VEC_MAX{cfg_interrupt_msi_enable[0]}};

  cndm_msi_rr_sel u_rr_sel (
    .i_req   (w_elig),
    .i_ptr   (r_rr),
    .o_valid (w_sel_valid),
    .o_index (w_sel_idx)
  );

  // New requests are OR-ed in last so a set beats a same-cycle clear.
  always_comb begin
    w_pend_next = r_pending;
    if (r_state == IDLE && w_sel_valid) w_pend_next[w_sel_idx] = 1'b0;
    if (r_state == WAIT && cfg_interrupt_msi_fail) w_pend_next[r_sel] = 1'b1;
    w_pend_next = w_pend_next | w_req_fold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_mask    <= '0;
      r_int     <= '0;
      r_pde     <= 1'b0;
      r_rr      <= 5'd0;
      r_sel     <= 5'd0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pend_next;
      r_pde     <= (w_pend_next != r_pending);
      if (cfg_interrupt_msi_mask_update) r_mask <= cfg_interrupt_msi_data;
      case (r_state)
        IDLE: begin
          if (w_sel_valid) begin
            r_sel   <= w_sel_idx;
            r_int   <= 32'd1 << w_sel_idx;
            r_rr    <= w_sel_idx + 5'd1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_int   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (cfg_interrupt_msi_fail) begin
            r_cnt   <= CNT_W'(RETRY_DELAY);
            r_state <= BACKOFF;
          end else if (cfg_interrupt_msi_sent) begin
            r_state <= IDLE;
          end
        end
        BACKOFF: begin
          // Leaving on the 1->0 step gives exactly RETRY_DELAY backoff cycles.
          if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign irq_busy                                      = (r_state != IDLE);
  assign dbg_state                                     = r_state;
  assign cfg_interrupt_msi_int                         = r_int;
  assign cfg_interrupt_msi_pending_status              = r_pending;
  assign cfg_interrupt_msi_pending_status_data_enable  = r_pde;
  assign cfg_interrupt_msi_select                      = 2'd0;
  assign cfg_interrupt_msi_pending_status_function_num = 2'd0;
  assign cfg_interrupt_msi_attr                        = 3'd0;
  assign cfg_interrupt_msi_tph_present                 = 1'b0;
  assign cfg_interrupt_msi_tph_type                    = 2'd0;
  assign cfg_interrupt_msi_tph_st_tag                  = 8'd0;
  assign cfg_interrupt_msi_function_number             = 8'd0;

endmodule

// File: doc/cndm_msi_irq_ctrl.md
Name: cndm_msi_irq_ctrl

Overview:
Collects per-vector interrupt request pulses from the cndm datapath (event/completion queues) and sequences them onto the PCIe hard block's MSI request interface (cfg_interrupt_msi_*). Coalesces requests per vector, respects MSI enable, allocated vector count and per-vector mask, and retries on fail. Sits in the pcie_clk domain between the cndm core and the PCIe core config-interrupt port, function 0 only.

Parameters:
IRQ_CNT, 32, number of request vectors (1..32)
RETRY_DELAY, 64, backoff cycles after cfg_interrupt_msi_fail before re-arbitration (>=1)

Ports:
clk  in  1  pcie_clk
rst  in  1  asynchronous active-high reset
irq_req  in  IRQ_CNT  one-cycle request pulse per vector; multiple bits may be set
irq_busy  out  1  high in any state other than IDLE
cfg_interrupt_msi_enable  in  4  bit 0 = function 0 MSI enable
cfg_interrupt_msi_mmenable  in  12  bits [2:0] = log2 allocated vectors, function 0
cfg_interrupt_msi_mask_update  in  1  pulse: mask register changed
cfg_interrupt_msi_data  in  32  mask value for selected function
cfg_interrupt_msi_select  out  2  constant 0
cfg_interrupt_msi_int  out  32  one-hot MSI request
cfg_interrupt_msi_pending_status  out  32  current pending vector bits
cfg_interrupt_msi_pending_status_data_enable  out  1  pulse when pending_status changes
cfg_interrupt_msi_pending_status_function_num  out  2  constant 0
cfg_interrupt_msi_sent  in  1  MSI sent pulse
cfg_interrupt_msi_fail  in  1  MSI failed pulse
cfg_interrupt_msi_attr  out  3  constant 0
cfg_interrupt_msi_tph_present  out  1  constant 0
cfg_interrupt_msi_tph_type  out  2  constant 0
cfg_interrupt_msi_tph_st_tag  out  8  constant 0
cfg_interrupt_msi_function_number  out  8  constant 0

Behaviour:
- Reset: all outputs 0; pending = 0, mask = 0, rr pointer = 0, backoff counter = 0, state IDLE.
- Vector mapping: mapped = irq index & ((1 << min(mmenable[2:0],5)) - 1); requests folded (OR) into pending[mapped]. Bits of pending above IRQ_CNT stay 0.
- Pending: set at next edge after irq_req; repeated requests on a pending vector coalesce into one MSI. A set and a clear on the same bit in the same cycle resolve to set.
- Mask: on mask_update, mask <= cfg_interrupt_msi_data at the next edge. Masked vectors stay pending, are never issued, and remain visible in pending_status.
- eligible = pending & ~mask, qualified by msi_enable[0]. If enable is 0, nothing is issued and pending is retained.
- FSM:
  IDLE: if eligible != 0, select the lowest eligible index at or above the rr pointer (wrapping); clear that pending bit, register int = one-hot, rr pointer = sel+1 mod 32 -> ISSUE.
  ISSUE: int held for exactly one cycle, then 0 -> WAIT.
  WAIT: on sent -> IDLE. On fail -> re-set pending[sel], load counter = RETRY_DELAY -> BACKOFF. sent and fail together: treated as fail. Enable dropping in WAIT has no effect; the FSM waits for the core's response.
  BACKOFF: decrement each cycle; at 0 -> IDLE. New requests accumulate meanwhile.
- Latency: with the FSM idle, an irq_req at edge n gives int high during cycle n+2 (pending set at n+1, IDLE decision at n+2).
- pending_status = pending register (registered). data_enable pulses one cycle, coincident with the updated value, after any change.
- Sent pulses arriving in IDLE or BACKOFF are ignored.
- Async reset mid-transaction discards pending and in-flight state; no retry after reset.

Decomposition:
- Package cndm_msi_pkg: FSM state enum (IDLE, ISSUE, WAIT, BACKOFF) and MSI_VEC_MAX = 32.
- Sub-module cndm_msi_rr_sel: combinational 32-bit round-robin find-first from pointer, with outputs valid and index[4:0].
- FSM, pending, mask and counter stay in the top.

Test Plan:
- mmenable=5, enable=1, pulse irq_req[3] -> int=0x8 for exactly one cycle, 2 cycles after the pulse; sent -> idle, pending_status 0x8 then 0x0, with two data_enable pulses.
- Pulse bits 1, 2 and 5 together, ack each with sent -> int order 0x2, 0x4, 0x20; a later irq 1 issues after 5 (round robin).
- mask_update with data=0x10, pulse irq 4 -> no int, pending_status=0x10; mask_update data=0 -> int=0x10.
- Issue vector 0, respond fail, RETRY_DELAY=64 -> int=0x1 again no earlier than 64 cycles later; then sent clears it.
- mmenable=2, pulse irq_req[6] -> int=0x4 (6&3=2); enable=0 with irq 1 pending -> no int until enable=1.
- Assert rst during WAIT -> all outputs 0 immediately, pending cleared, a subsequent sent is ignored, then normal operation resumes.
